fft_controller: RTL and testbench

Sequencer for the in-place radix-2 DIT FFT engine. It generates the read addresses and twiddle-ROM index that feed the butterfly. It also generates the write-back addresses, write enables and stage scale flag, latency-matched to the butterfly outputs. It sits between the FFT sample RAM (dual-port: two read ports, two write ports) and the butterfly datapath, and sequences all log2(FFT_SIZE) stages after a start pulse.

---
 rtl/fft_controller_pkg.sv | 11 +
 rtl/fft_delay_line.sv | 25 ++
 rtl/fft_controller.sv | 139 +++++++++++++
 tb/tb_fft_controller.sv | 250 +++++++++++++++++++++++++
 4 files changed

// File: rtl/fft_controller_pkg.sv
// Shared types for the FFT sequencer: FSM state encoding.
package fft_controller_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    DRAIN = 2'd2,
    DONE  = 2'd3
  } fft_state_e;

endpackage

// File: rtl/fft_delay_line.sv
// WIDTH x DEPTH shift register with async active-low clear.
module fft_delay_line #(
  parameter int WIDTH = 1,
  parameter int DEPTH = 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] dout
);

  logic [WIDTH-1:0] pipe_q [DEPTH];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) pipe_q[i] <= '0;
    end else begin
      pipe_q[0] <= din;
      for (int i = 1; i < DEPTH; i++) pipe_q[i] <= pipe_q[i-1];
    end
  end

  assign dout = pipe_q[DEPTH-1];

endmodule

// File: rtl/fft_controller.sv
// In-place radix-2 DIT FFT sequencer: read/twiddle address generation per stage
// and a latency-matched write-back path.
//
// state | meaning
// IDLE  | waiting for start
// RUN   | one butterfly read per cycle, b = 0..FFT_SIZE/2-1
// DRAIN | no reads for PIPE cycles so the stage's writes land first
// DONE  | one-cycle done pulse
module fft_controller
  import fft_controller_pkg::*;
#(
  parameter int FFT_SIZE     = 4096,
  parameter int RD_LATENCY   = 1,
  parameter int BFLY_LATENCY = 5,
  localparam int ADDR_W      = $clog2(FFT_SIZE)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  output logic              busy,
  output logic              done,
  output logic              rd_en,
  output logic [ADDR_W-1:0] rd_addra,
  output logic [ADDR_W-1:0] rd_addrb,
  output logic [ADDR_W-2:0] twiddle_addr,
  output logic              wr_en,
  output logic [ADDR_W-1:0] wr_addra,
  output logic [ADDR_W-1:0] wr_addrb,
  output logic              scale
);

  localparam int LOG2N = ADDR_W;
  localparam int PIPE  = RD_LATENCY + BFLY_LATENCY;
  localparam int HALF  = FFT_SIZE / 2;
  localparam int S_W   = $clog2(LOG2N);
  localparam int CNT_W = $clog2(PIPE + 1);
  localparam int DL_W  = 2 * ADDR_W + 2;

  fft_state_e        state, state_nx;
  logic [S_W-1:0]    s, s_nx;
  logic [ADDR_W-2:0] b, b_nx;
  logic [CNT_W-1:0]  cnt, cnt_nx;

  logic [ADDR_W-1:0] b_ext, mask, addra_nx, addrb_nx;
  logic [ADDR_W-2:0] tw_nx;
  logic              run_nx;
  logic              rd_scale;
  logic [DL_W-1:0]   dl_out;

  always_comb begin
    state_nx = state;
    s_nx     = s;
    b_nx     = b;
    cnt_nx   = cnt;
    unique case (state)
      IDLE: begin
        if (start) begin
          state_nx = RUN;
          s_nx     = '0;
          b_nx     = '0;
        end
      end
      RUN: begin
        if (b == (ADDR_W-1)'(HALF - 1)) begin
          state_nx = DRAIN;
          cnt_nx   = CNT_W'(PIPE - 1);
        end else begin
          b_nx = b + 1'b1;
        end
      end
      DRAIN: begin
        if (cnt == '0) begin
          if (s == S_W'(LOG2N - 1)) begin
            state_nx = DONE;
          end else begin
            state_nx = RUN;
            s_nx     = s + 1'b1;
            b_nx     = '0;
          end
        end else begin
          cnt_nx = cnt - 1'b1;
        end
      end
      DONE: state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  // (b & ~mask) << 1 is ((b >> s) << (s+1)) without needing an s+1 shift count.
  always_comb begin
    run_nx   = (state_nx == RUN);
    b_ext    = {1'b0, b_nx};
    mask     = (ADDR_W'(1) << s_nx) - ADDR_W'(1);
    addra_nx = ((b_ext & ~mask) << 1) | (b_ext & mask);
    addrb_nx = addra_nx | (ADDR_W'(1) << s_nx);
    tw_nx    = (b_nx & mask[ADDR_W-2:0]) << (S_W'(LOG2N - 1) - s_nx);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state        <= IDLE;
      s            <= '0;
      b            <= '0;
      cnt          <= '0;
      busy         <= 1'b0;
      done         <= 1'b0;
      rd_en        <= 1'b0;
      rd_addra     <= '0;
      rd_addrb     <= '0;
      twiddle_addr <= '0;
      rd_scale     <= 1'b0;
    end else begin
      state        <= state_nx;
      s            <= s_nx;
      b            <= b_nx;
      cnt          <= cnt_nx;
      busy         <= (state_nx != IDLE);
      done         <= (state_nx == DONE);
      rd_en        <= run_nx;
      rd_addra     <= run_nx ? addra_nx : '0;
      rd_addrb     <= run_nx ? addrb_nx : '0;
      twiddle_addr <= run_nx ? tw_nx : '0;
      rd_scale     <= run_nx & s_nx[0];
    end
  end

  fft_delay_line #(
    .WIDTH (DL_W),
    .DEPTH (PIPE)
  ) u_wr_delay (
    .clk   (clk),
    .rst_n (rst_n),
    .din   ({rd_en, rd_addra, rd_addrb, rd_scale}),
    .dout  (dl_out)
  );

  assign {wr_en, wr_addra, wr_addrb, scale} = dl_out;

endmodule

// File: tb/tb_fft_controller.sv
// Directed bench for fft_controller at FFT_SIZE=16 (PIPE=6, stage period 14).
module tb_fft_controller;

  logic       clk;
  logic       rst_n;
  logic       start;
  logic       busy, done, rd_en, wr_en, scale;
  logic [3:0] rd_addra, rd_addrb, wr_addra, wr_addrb;
  logic [2:0] twiddle_addr;

  int checks = 0;
  int errors = 0;

  fft_controller #(
    .FFT_SIZE     (16),
    .RD_LATENCY   (1),
    .BFLY_LATENCY (5)
  ) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .start        (start),
    .busy         (busy),
    .done         (done),
    .rd_en        (rd_en),
    .rd_addra     (rd_addra),
    .rd_addrb     (rd_addrb),
    .twiddle_addr (twiddle_addr),
    .wr_en        (wr_en),
    .wr_addra     (wr_addra),
    .wr_addrb     (wr_addrb),
    .scale        (scale)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Expected read for cycle rel after the start-sampling edge, built from groups of 2*span.
  function automatic void model_rd(input int rel, output bit en, output int a,
                                   output int bb, output int tw, output int stg);
    int k, span, g, j;
    en = 0; a = 0; bb = 0; tw = 0; stg = 0;
    if (rel >= 1 && rel <= 56) begin
      stg = (rel - 1) / 14;
      k   = (rel - 1) % 14;
      if (k < 8) begin
        span = 1 << stg;
        g    = k / span;
        j    = k % span;
        a    = g * 2 * span + j;
        bb   = a + span;
        tw   = j * (8 / span);
        en   = 1;
      end
    end
  endfunction

  task automatic test_reset();
    rst_n = 1'b0;
    start = 1'b0;
    repeat (3) @(negedge clk);
    checks++;
    if ({busy, done, rd_en, wr_en, scale} !== 5'b0 || rd_addra !== 4'd0 || rd_addrb !== 4'd0 ||
        wr_addra !== 4'd0 || wr_addrb !== 4'd0 || twiddle_addr !== 3'd0) begin
      errors++;
      $display("FAIL reset_hold got busy=%b done=%b rd_en=%b wr_en=%b ra=%0d rb=%0d tw=%0d exp all 0",
               busy, done, rd_en, wr_en, rd_addra, rd_addrb, twiddle_addr);
    end
    rst_n = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      checks++;
      if ({busy, done, rd_en, wr_en, scale} !== 5'b0 || rd_addra !== 4'd0 || rd_addrb !== 4'd0 ||
          wr_addra !== 4'd0 || wr_addrb !== 4'd0 || twiddle_addr !== 3'd0) begin
        errors++;
        $display("FAIL idle_no_start i=%0d got busy=%b rd_en=%b wr_en=%b ra=%0d rb=%0d exp all 0",
                 i, busy, rd_en, wr_en, rd_addra, rd_addrb);
      end
    end
  endtask

  // Full transform: handshake, addressing, write alignment; ignored start at 20, new start at 58.
  task automatic test_full_transform();
    int  exp_a[0:63];
    int  exp_b[0:63];
    int  exp_s[0:63];
    bit  exp_en[0:63];
    int  wr_count[4];
    int  s1_a[8] = '{0, 1, 4, 5, 8, 9, 12, 13};
    int  s1_b[8] = '{2, 3, 6, 7, 10, 11, 14, 15};
    int  s1_t[8] = '{0, 4, 0, 4, 0, 4, 0, 4};
    bit  en;
    int  a, bb, tw, stg, src;
    for (int i = 0; i < 4; i++) wr_count[i] = 0;
    for (int i = 0; i < 64; i++) begin
      exp_en[i] = 0; exp_a[i] = 0; exp_b[i] = 0; exp_s[i] = 0;
    end
    @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    for (int cyc = 1; cyc <= 58; cyc++) begin
      start = (cyc == 20 || cyc == 58);
      model_rd(cyc, en, a, bb, tw, stg);
      exp_en[cyc] = en; exp_a[cyc] = a; exp_b[cyc] = bb; exp_s[cyc] = stg;
      checks++;
      if (rd_en !== en) begin
        errors++;
        $display("FAIL rd_en cyc=%0d got=%b exp=%b", cyc, rd_en, en);
      end
      checks++;
      if (busy !== (cyc <= 57)) begin
        errors++;
        $display("FAIL busy cyc=%0d got=%b exp=%b", cyc, busy, cyc <= 57);
      end
      checks++;
      if (done !== (cyc == 57)) begin
        errors++;
        $display("FAIL done cyc=%0d got=%b exp=%b", cyc, done, cyc == 57);
      end
      if (en) begin
        checks++;
        if (rd_addra !== 4'(a) || rd_addrb !== 4'(bb) || twiddle_addr !== 3'(tw)) begin
          errors++;
          $display("FAIL rd_addr cyc=%0d got=(%0d,%0d) tw=%0d exp=(%0d,%0d) tw=%0d",
                   cyc, rd_addra, rd_addrb, twiddle_addr, a, bb, tw);
        end
      end
      if (cyc >= 15 && cyc <= 22) begin
        checks++;
        if (rd_addra !== 4'(s1_a[cyc-15]) || rd_addrb !== 4'(s1_b[cyc-15]) ||
            twiddle_addr !== 3'(s1_t[cyc-15])) begin
          errors++;
          $display("FAIL stage1_table cyc=%0d got=(%0d,%0d) tw=%0d exp=(%0d,%0d) tw=%0d", cyc,
                   rd_addra, rd_addrb, twiddle_addr, s1_a[cyc-15], s1_b[cyc-15], s1_t[cyc-15]);
        end
      end
      src = cyc - 6;
      en  = (src >= 1) ? exp_en[src] : 1'b0;
      checks++;
      if (wr_en !== en) begin
        errors++;
        $display("FAIL wr_en cyc=%0d got=%b exp=%b", cyc, wr_en, en);
      end
      if (wr_en === 1'b1) wr_count[exp_s[cyc > 6 ? src : 0]]++;
      if (en) begin
        checks++;
        if (wr_addra !== 4'(exp_a[src]) || wr_addrb !== 4'(exp_b[src]) ||
            scale !== exp_s[src][0]) begin
          errors++;
          $display("FAIL wr_align cyc=%0d got=(%0d,%0d) scale=%b exp=(%0d,%0d) scale=%b", cyc,
                   wr_addra, wr_addrb, scale, exp_a[src], exp_b[src], exp_s[src][0]);
        end
      end
      @(negedge clk);
    end
    start = 1'b0;
    for (int i = 0; i < 4; i++) begin
      checks++;
      if (wr_count[i] != 8) begin
        errors++;
        $display("FAIL wr_count stage=%0d got=%0d exp=8", i, wr_count[i]);
      end
    end
  endtask

  // Continues straight from the start issued in cycle 58.
  task automatic test_back_to_back();
    bit en;
    int a, bb, tw, stg;
    for (int cyc = 59; cyc <= 116; cyc++) begin
      model_rd(cyc - 58, en, a, bb, tw, stg);
      checks++;
      if (rd_en !== en) begin
        errors++;
        $display("FAIL b2b_rd_en cyc=%0d got=%b exp=%b", cyc, rd_en, en);
      end
      checks++;
      if (done !== (cyc == 115) || busy !== (cyc <= 115)) begin
        errors++;
        $display("FAIL b2b_handshake cyc=%0d got done=%b busy=%b exp done=%b busy=%b",
                 cyc, done, busy, cyc == 115, cyc <= 115);
      end
      if (cyc == 59) begin
        checks++;
        if (rd_addra !== 4'd0 || rd_addrb !== 4'd1) begin
          errors++;
          $display("FAIL b2b_first_addr got=(%0d,%0d) exp=(0,1)", rd_addra, rd_addrb);
        end
      end
      @(negedge clk);
    end
  endtask

  task automatic test_reset_mid_run();
    @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (35) @(negedge clk);
    checks++;
    if (rd_en !== 1'b1 || wr_en !== 1'b1 || busy !== 1'b1) begin
      errors++;
      $display("FAIL midrun_active got rd_en=%b wr_en=%b busy=%b exp 1 1 1", rd_en, wr_en, busy);
    end
    rst_n = 1'b0;
    #1;
    checks++;
    if (rd_en !== 1'b0 || wr_en !== 1'b0 || busy !== 1'b0 || done !== 1'b0) begin
      errors++;
      $display("FAIL midrun_reset got rd_en=%b wr_en=%b busy=%b done=%b exp all 0",
               rd_en, wr_en, busy, done);
    end
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    checks++;
    if (rd_en !== 1'b0 || wr_en !== 1'b0 || busy !== 1'b0) begin
      errors++;
      $display("FAIL post_reset_idle got rd_en=%b wr_en=%b busy=%b exp 0 0 0", rd_en, wr_en, busy);
    end
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    checks++;
    if (rd_en !== 1'b1 || rd_addra !== 4'd0 || rd_addrb !== 4'd1 || twiddle_addr !== 3'd0 ||
        busy !== 1'b1) begin
      errors++;
      $display("FAIL restart_first got rd_en=%b (%0d,%0d) tw=%0d busy=%b exp 1 (0,1) tw=0 busy=1",
               rd_en, rd_addra, rd_addrb, twiddle_addr, busy);
    end
    repeat (6) @(negedge clk);
    checks++;
    if (wr_en !== 1'b1 || wr_addra !== 4'd0 || wr_addrb !== 4'd1 || scale !== 1'b0) begin
      errors++;
      $display("FAIL restart_first_wr got wr_en=%b (%0d,%0d) scale=%b exp 1 (0,1) scale=0",
               wr_en, wr_addra, wr_addrb, scale);
    end
  endtask

  initial begin
    rst_n = 1'b0;
    start = 1'b0;
    test_reset();
    test_full_transform();
    test_back_to_back();
    test_reset_mid_run();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
